// File: rtl/reg_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback_if
// Description : Bundles the ALU result port, the load return handshake,
//               the decode hazard query and the register file write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_writeback_if #(
  parameter int DEPTH = 2
);
  localparam int c_cw = $clog2(DEPTH) + 1;

  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [31:0]     alu_data;
  logic            alu_stall;

  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [31:0]     ld_data;
  logic [c_cw-1:0] ld_count;

  logic [4:0]      hz_rs;
  logic            hz_busy;

  logic            WEN;
  logic [4:0]      RW;
  logic [31:0]     busW;

  // Upstream side: ALU, load return path, decode and register file observer.
  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_stall,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready, ld_count,
    output hz_rs,
    input  hz_busy,
    input  WEN, RW, busW
  );

  // Write-back block side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_stall,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready, ld_count,
    input  hz_rs,
    output hz_busy,
    output WEN, RW, busW
  );
endinterface
`default_nettype wire

// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback
// Description : Register file write-port initiator. Merges the in-order ALU
//               result (priority, no backpressure) with load returns buffered
//               in a small FIFO, answers decode hazard queries and stalls the
//               ALU periodically so queued loads cannot starve.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_writeback #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            Clk,
  input  logic            rst,
  reg_writeback_if.slave  bus
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam int c_sw = $clog2(STARVE_MAX + 1);

  localparam logic [c_cw-1:0] c_depth      = c_cw'(DEPTH);
  localparam logic [c_sw-1:0] c_starve_max = c_sw'(STARVE_MAX);

  // Load FIFO storage and bookkeeping
  logic [4:0]      r_rd_mem   [DEPTH];
  logic [31:0]     r_data_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_cw-1:0] r_count;

  // Anti-starvation state
  logic [c_sw-1:0] r_starve;
  logic            r_stall;

  // Register file write port
  logic            r_wen;
  logic [4:0]      r_rw;
  logic [31:0]     r_busw;

  logic            w_full;
  logic            w_empty;
  logic            w_ld_ready;
  logic            w_push;
  logic            w_alu_win;
  logic            w_pop;
  logic [c_sw-1:0] w_starve_inc;
  logic            w_starve_hit;
  logic [DEPTH-1:0] w_match;

  assign w_full     = (r_count == c_depth);
  assign w_empty    = (r_count == '0);
  // Full FIFO refuses a push even if it pops this cycle: no enqueue-through-pop.
  assign w_ld_ready = ~w_full & ~rst;
  // Loads to r0 complete the handshake but are never stored.
  assign w_push     = bus.ld_valid & w_ld_ready & (bus.ld_rd != 5'd0);
  // An ALU result to r0 is a non-write; the slot goes to the FIFO instead.
  assign w_alu_win  = bus.alu_valid & (bus.alu_rd != 5'd0);
  assign w_pop      = ~w_alu_win & ~w_empty;

  // An ALU win during a stall cycle is a protocol violation and does not count.
  assign w_starve_inc = r_starve + c_sw'(1);
  assign w_starve_hit = w_alu_win & ~r_stall & ~w_empty & (w_starve_inc == c_starve_max);

  // Hazard match against every occupied FIFO slot; offset from head decides occupancy.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_hz
      logic [c_aw-1:0] w_off;
      assign w_off      = c_aw'(i) - r_rd_ptr;
      assign w_match[i] = ({1'b0, w_off} < r_count) && (r_rd_mem[i] == bus.hz_rs);
    end
  endgenerate

  // The output stage counts as pending: the register file has no write-to-read bypass.
  assign bus.hz_busy   = (bus.hz_rs != 5'd0) &&
                         ((|w_match) || (r_wen && (r_rw == bus.hz_rs)));
  assign bus.ld_ready  = w_ld_ready;
  assign bus.ld_count  = r_count;
  assign bus.alu_stall = r_stall;
  assign bus.WEN       = r_wen;
  assign bus.RW        = r_rw;
  assign bus.busW      = r_busw;

  // FIFO payload write at the tail; contents need no reset since occupancy gates use.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_rd_mem[r_wr_ptr]   <= bus.ld_rd;
      r_data_mem[r_wr_ptr] <= bus.ld_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge Clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Starvation counter and the one-cycle ALU stall it triggers.
  always_ff @(posedge Clk) begin
    if (rst) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_stall <= w_starve_hit;
      if (w_pop || w_empty || w_starve_hit) begin
        r_starve <= '0;
      end else if (w_alu_win && !r_stall) begin
        r_starve <= w_starve_inc;
      end
    end
  end

  // Register file write port: ALU first, then FIFO head, otherwise hold address/data.
  always_ff @(posedge Clk) begin
    if (rst) begin
      r_wen  <= 1'b0;
      r_rw   <= 5'd0;
      r_busw <= 32'd0;
    end else if (w_alu_win) begin
      r_wen  <= 1'b1;
      r_rw   <= bus.alu_rd;
      r_busw <= bus.alu_data;
    end else if (w_pop) begin
      r_wen  <= 1'b1;
      r_rw   <= r_rd_mem[r_rd_ptr];
      r_busw <= r_data_mem[r_rd_ptr];
    end else begin
      r_wen  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_writeback
// Description : Directed self-checking bench for reg_writeback
//               (DEPTH=2, STARVE_MAX=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_writeback;

  logic Clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  reg_writeback_if #(.DEPTH(2)) bus ();

  reg_writeback #(
    .DEPTH      (2),
    .STARVE_MAX (4)
  ) dut (
    .Clk (Clk),
    .rst (rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge Clk);
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'd0;
    bus.ld_valid  = 1'b0;
    bus.ld_rd     = 5'd0;
    bus.ld_data   = 32'd0;
    bus.hz_rs     = 5'd0;
  endtask

  initial begin
    int q[$];
    int idx;
    int nwr;
    int wen_seen;
    int e;
    logic acc;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle();

    // ---------------- 1. reset, ALU write, load write
    cyc(); cyc();
    check("rst_wen",    32'(bus.WEN), 0);
    check("rst_rw",     32'(bus.RW), 0);
    check("rst_busw",   bus.busW, 0);
    check("rst_stall",  32'(bus.alu_stall), 0);
    check("rst_count",  32'(bus.ld_count), 0);
    check("rst_ready",  32'(bus.ld_ready), 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(bus.ld_ready), 1);

    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    cyc();
    check("alu_wen",  32'(bus.WEN), 1);
    check("alu_rw",   32'(bus.RW), 5);
    check("alu_busw", bus.busW, 32'hDEADBEEF);
    bus.alu_valid = 1'b0;
    cyc();
    check("alu_wen_off", 32'(bus.WEN), 0);
    check("alu_rw_hold", 32'(bus.RW), 5);

    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h12345678;
    cyc();
    check("ld1_count", 32'(bus.ld_count), 1);
    check("ld1_wen0",  32'(bus.WEN), 0);
    bus.ld_valid = 1'b0;
    cyc();
    check("ld1_wen",   32'(bus.WEN), 1);
    check("ld1_rw",    32'(bus.RW), 7);
    check("ld1_busw",  bus.busW, 32'h12345678);
    check("ld1_empty", 32'(bus.ld_count), 0);

    // ---------------- 2. full FIFO, backpressure and starvation stall
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd20; bus.ld_data = 32'hA0;
    cyc();
    check("st_e1_count", 32'(bus.ld_count), 1);
    check("st_e1_rw",    32'(bus.RW), 1);
    bus.alu_rd = 5'd2; bus.ld_rd = 5'd21; bus.ld_data = 32'hA1;
    cyc();
    check("st_full_count", 32'(bus.ld_count), 2);
    check("st_full_ready", 32'(bus.ld_ready), 0);
    check("st_e2_stall",   32'(bus.alu_stall), 0);
    bus.ld_rd = 5'd22; bus.ld_data = 32'hA2;
    bus.alu_rd = 5'd3;
    cyc();
    check("st_e3_stall", 32'(bus.alu_stall), 0);
    bus.alu_rd = 5'd4;
    cyc();
    check("st_e4_stall", 32'(bus.alu_stall), 0);
    check("st_e4_count", 32'(bus.ld_count), 2);
    bus.alu_rd = 5'd5;
    cyc();
    check("st_stall",    32'(bus.alu_stall), 1);
    check("st_stall_rw", 32'(bus.RW), 5);
    check("st_stall_rdy", 32'(bus.ld_ready), 0);
    bus.alu_valid = 1'b0;
    cyc();
    check("st_stall_off", 32'(bus.alu_stall), 0);
    check("st_head_wen",  32'(bus.WEN), 1);
    check("st_head_rw",   32'(bus.RW), 20);
    check("st_head_busw", bus.busW, 32'hA0);
    check("st_ready_back", 32'(bus.ld_ready), 1);
    check("st_count_1",   32'(bus.ld_count), 1);
    cyc();
    check("st_pushpop_rw",    32'(bus.RW), 21);
    check("st_pushpop_count", 32'(bus.ld_count), 1);
    bus.ld_valid = 1'b0;
    cyc();
    check("st_third_rw",   32'(bus.RW), 22);
    check("st_third_busw", bus.busW, 32'hA2);
    check("st_drained",    32'(bus.ld_count), 0);
    cyc();
    check("st_idle_wen", 32'(bus.WEN), 0);

    // ---------------- 3. r0 handling
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'h10;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd9;  bus.ld_data  = 32'h99;
    cyc();
    check("r0_alu_rw", 32'(bus.RW), 10);
    check("r0_count",  32'(bus.ld_count), 1);
    bus.ld_valid = 1'b0;
    bus.alu_rd = 5'd0; bus.alu_data = 32'hBAD0BAD0;
    cyc();
    check("r0_wen",   32'(bus.WEN), 1);
    check("r0_rw",    32'(bus.RW), 9);
    check("r0_busw",  bus.busW, 32'h99);
    check("r0_count0", 32'(bus.ld_count), 0);
    bus.alu_valid = 1'b0;
    cyc();
    check("r0_alu_nowen", 32'(bus.WEN), 0);
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'h55;
    #1;
    check("r0_ld_ready", 32'(bus.ld_ready), 1);
    cyc();
    check("r0_ld_count", 32'(bus.ld_count), 0);
    check("r0_ld_wen",   32'(bus.WEN), 0);
    bus.ld_valid = 1'b0;
    cyc();
    check("r0_ld_wen2",  32'(bus.WEN), 0);

    // ---------------- 4. hazard query
    bus.hz_rs = 5'd12;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h3;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd12; bus.ld_data = 32'hC12;
    #1;
    check("hz_before", 32'(bus.hz_busy), 0);
    cyc();
    check("hz_queued", 32'(bus.hz_busy), 1);
    bus.alu_valid = 1'b0; bus.ld_valid = 1'b0;
    cyc();
    check("hz_out_rw",  32'(bus.RW), 12);
    check("hz_out_wen", 32'(bus.WEN), 1);
    check("hz_out",     32'(bus.hz_busy), 1);
    cyc();
    check("hz_clear", 32'(bus.hz_busy), 0);
    bus.hz_rs = 5'd3;
    #1;
    check("hz_other", 32'(bus.hz_busy), 0);
    bus.hz_rs = 5'd0;
    #1;
    check("hz_r0", 32'(bus.hz_busy), 0);

    // ---------------- 5. ordering and pointer wrap
    idx = 0; nwr = 0;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd2; bus.ld_data = 32'h222;
    for (int c = 0; c < 12; c++) begin
      acc = bus.ld_valid && bus.ld_ready;
      if (acc) q.push_back(idx + 2);
      cyc();
      if (bus.WEN) begin
        if (q.size() == 0) begin
          check("ord_extra_write", 32'(bus.RW), 0);
        end else begin
          e = q.pop_front();
          check("ord_rw",   32'(bus.RW), 32'(e));
          check("ord_busw", bus.busW, 32'(e) * 32'h111);
          nwr++;
        end
      end
      check("ord_count_le2", 32'(bus.ld_count <= 2'd2), 1);
      if (acc) begin
        idx++;
        if (idx < 6) begin
          bus.ld_rd   = 5'(idx + 2);
          bus.ld_data = 32'(idx + 2) * 32'h111;
        end else begin
          bus.ld_valid = 1'b0;
        end
      end
    end
    check("ord_writes", 32'(nwr), 6);

    // ---------------- 6. reset mid-operation
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd13; bus.ld_data = 32'hD13;
    cyc();
    bus.ld_rd = 5'd14; bus.ld_data = 32'hD14;
    cyc();
    check("mr_full", 32'(bus.ld_count), 2);
    bus.alu_valid = 1'b0; bus.ld_valid = 1'b0;
    rst = 1'b1;
    cyc();
    check("mr_wen",   32'(bus.WEN), 0);
    check("mr_count", 32'(bus.ld_count), 0);
    check("mr_stall", 32'(bus.alu_stall), 0);
    check("mr_ready", 32'(bus.ld_ready), 0);
    rst = 1'b0;
    bus.hz_rs = 5'd13;
    #1;
    check("mr_hz", 32'(bus.hz_busy), 0);
    wen_seen = 0;
    for (int c = 0; c < 4; c++) begin
      cyc();
      if (bus.WEN) wen_seen++;
    end
    check("mr_no_write", 32'(wen_seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
